// File: rtl/cla_adder_nbit.sv
// Parameterised two-level carry-lookahead adder with a registered result.
// Bits are grouped in fours; a second lookahead level spans the groups.
module cla_adder_nbit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    localparam int unsigned GROUP = 4;
    localparam int unsigned NGRP  = (WIDTH + GROUP - 1) / GROUP;
    localparam int unsigned PW    = NGRP * GROUP;
    localparam int unsigned LAW   = 8;

    // Carry into position n of a generate/propagate vector, flattened as a
    // sum of products (no rippling): OR over j<n of g[j]&p[j+1..n-1], plus c0&p[0..n-1].
    function automatic logic carry_la(input logic [LAW-1:0] gv,
                                      input logic [LAW-1:0] pv,
                                      input logic           c0,
                                      input int unsigned    n);
        logic c;
        logic t;
        c = 1'b0;
        for (int unsigned j = 0; j < LAW; j++) begin
            if (j < n) begin
                t = gv[j];
                for (int unsigned m = j + 1; m < LAW; m++) begin
                    if (m < n) t = t & pv[m];
                end
                c = c | t;
            end
        end
        t = c0;
        for (int unsigned m = 0; m < LAW; m++) begin
            if (m < n) t = t & pv[m];
        end
        return c | t;
    endfunction

    logic [PW-1:0]   g_pad;
    logic [PW-1:0]   p_pad;
    logic [NGRP-1:0] grp_g;
    logic [NGRP-1:0] grp_p;
    logic [NGRP:0]   grp_c;
    logic [PW:0]     c;
    logic [WIDTH-1:0] sum_c;
    logic            cout_c;

    // Bit g/p, group G/P, group carry-ins, then per-bit carries inside each group.
    always_comb begin
        g_pad = '0;
        p_pad = '0;
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        c     = '0;

        g_pad[WIDTH-1:0] = a & b;
        p_pad[WIDTH-1:0] = a ^ b;

        for (int unsigned k = 0; k < NGRP; k++) begin
            grp_g[k] = carry_la(LAW'(g_pad[GROUP*k +: GROUP]),
                                LAW'(p_pad[GROUP*k +: GROUP]), 1'b0, GROUP);
            grp_p[k] = &p_pad[GROUP*k +: GROUP];
        end

        for (int unsigned k = 0; k <= NGRP; k++) begin
            grp_c[k] = carry_la(LAW'(grp_g), LAW'(grp_p), cin, k);
        end

        for (int unsigned k = 0; k < NGRP; k++) begin
            for (int unsigned i = 0; i < GROUP; i++) begin
                c[GROUP*k + i] = carry_la(LAW'(g_pad[GROUP*k +: GROUP]),
                                          LAW'(p_pad[GROUP*k +: GROUP]),
                                          grp_c[k], i);
            end
        end
        c[PW] = grp_c[NGRP];

        sum_c  = p_pad[WIDTH-1:0] ^ c[WIDTH-1:0];
        // Padding bits have g=p=0, so carries above WIDTH are always zero
        // and the OR reduces to the carry out of bit WIDTH-1.
        cout_c = |c[PW:WIDTH];
    end

    // Result register: reset wins, new result on in_valid, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_c;
                cout <= cout_c;
            end
        end
    end

endmodule

// File: tb/tb_cla_adder_nbit.sv
// Scoreboard bench for cla_adder_nbit at WIDTH 4, 6 and 32 in parallel.
module tb_cla_adder_nbit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vin;
    logic [3:0]  a4, b4, s4;
    logic        c4, co4, ov4;
    logic [5:0]  a6, b6, s6;
    logic        c6, co6, ov6;
    logic [31:0] a32, b32, s32;
    logic        c32, co32, ov32;

    cla_adder_nbit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(vin), .a(a4), .b(b4), .cin(c4),
        .sum(s4), .cout(co4), .out_valid(ov4));
    cla_adder_nbit #(.WIDTH(6)) dut6 (
        .clk(clk), .rst(rst), .in_valid(vin), .a(a6), .b(b6), .cin(c6),
        .sum(s6), .cout(co6), .out_valid(ov6));
    cla_adder_nbit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(vin), .a(a32), .b(b32), .cin(c32),
        .sum(s32), .cout(co32), .out_valid(ov32));

    // Expected {out_valid, cout, sum} after one edge, per instance.
    typedef struct packed {
        logic [5:0]  e4;
        logic [7:0]  e6;
        logic [33:0] e32;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state: last reported {cout,sum} for each width.
    logic [4:0]  h4  = '0;
    logic [6:0]  h6  = '0;
    logic [32:0] h32 = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and record the expected response.
    task automatic step(input logic r, input logic vi,
                        input logic [3:0] xa4, input logic [3:0] xb4, input logic xc4,
                        input logic [5:0] xa6, input logic [5:0] xb6, input logic xc6,
                        input logic [31:0] xa32, input logic [31:0] xb32, input logic xc32);
        logic vo;
        @(negedge clk);
        rst = r;  vin = vi;
        a4 = xa4;   b4 = xb4;   c4 = xc4;
        a6 = xa6;   b6 = xb6;   c6 = xc6;
        a32 = xa32; b32 = xb32; c32 = xc32;
        if (r) begin
            h4 = '0; h6 = '0; h32 = '0; vo = 1'b0;
        end else if (vi) begin
            h4  = 5'(64'(xa4) + 64'(xb4) + 64'(xc4));
            h6  = 7'(64'(xa6) + 64'(xb6) + 64'(xc6));
            h32 = 33'(64'(xa32) + 64'(xb32) + 64'(xc32));
            vo  = 1'b1;
        end else begin
            vo = 1'b0;
        end
        q.push_back('{e4: {vo, h4}, e6: {vo, h6}, e32: {vo, h32}});
    endtask

    // Monitor: one expectation per clock edge, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("w4",  64'({ov4,  co4,  s4}),  64'(e.e4));
                check("w6",  64'({ov6,  co6,  s6}),  64'(e.e6));
                check("w32", 64'({ov32, co32, s32}), 64'(e.e32));
            end
        end
    end

    initial begin
        logic [12:0] idx;
        rst = 1'b1; vin = 1'b0;
        a4 = '0; b4 = '0; c4 = 1'b0;
        a6 = '0; b6 = '0; c6 = 1'b0;
        a32 = '0; b32 = '0; c32 = 1'b0;

        // Reset, including rst priority over in_valid.
        step(1, 0, 4'h0, 4'h0, 0, 6'h00, 6'h00, 0, 32'h0, 32'h0, 0);
        step(1, 1, 4'hF, 4'hF, 1, 6'h3F, 6'h3F, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);

        // Directed vectors, back to back.
        step(0, 1, 4'b1010, 4'b0110, 0, 6'b101010, 6'b100110, 0, 32'h12345678, 32'h9ABCDEF0, 0);
        step(0, 1, 4'b1010, 4'b0110, 1, 6'b101110, 6'b100110, 1, 32'hFFFFFFFF, 32'h00000000, 1);
        step(0, 1, 4'b1100, 4'b1111, 1, 6'b110100, 6'b001111, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        step(0, 1, 4'b1100, 4'b1111, 0, 6'b001100, 6'b011111, 0, 32'hAAAAAAAA, 32'h55555555, 1);
        // Gap: out_valid drops, outputs hold.
        step(0, 0, 4'h3, 4'h4, 1, 6'h11, 6'h22, 1, 32'h1, 32'h2, 1);
        // All-ones and full propagate chains.
        step(0, 1, 4'hF, 4'hF, 1, 6'h3F, 6'h3F, 1, 32'hAAAAAAAA, 32'h55555555, 0);
        step(0, 1, 4'hF, 4'h0, 1, 6'h3F, 6'h00, 1, 32'h0, 32'hFFFFFFFF, 1);
        // Reset mid-stream with in_valid high, then idle.
        step(0, 1, 4'h7, 4'h8, 0, 6'h15, 6'h2A, 0, 32'h7FFFFFFF, 32'h1, 0);
        step(1, 1, 4'h9, 4'h9, 1, 6'h21, 6'h21, 1, 32'h80000000, 32'h80000000, 1);
        step(0, 0, 4'h1, 4'h1, 1, 6'h01, 6'h01, 1, 32'h1, 32'h1, 1);

        // Exhaustive for W=6 (and W=4 repeatedly), random for W=32.
        for (int i = 0; i < 8192; i++) begin
            idx = 13'(i);
            step(0, 1, idx[3:0], idx[7:4], idx[8], idx[5:0], idx[11:6], idx[12],
                 $urandom, $urandom, 1'($urandom));
        end

        // Random traffic with gaps and occasional reset.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                 4'($urandom), 4'($urandom), 1'($urandom),
                 6'($urandom), 6'($urandom), 1'($urandom),
                 $urandom, $urandom, 1'($urandom));
        end

        step(0, 0, 4'h0, 4'h0, 0, 6'h00, 6'h00, 0, 32'h0, 32'h0, 0);
        @(posedge clk);
        #2;
        check("drain", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
